// File: rtl/mips_pkg.sv
// Shared constants for the MIPS program loader: HALT word, byte width, loader state encoding.
package mips_pkg;

  localparam int          BYTE_W     = 8;
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } loader_state_t;

endpackage

// File: rtl/instruction_loader.sv
// Assembles big-endian UART bytes into words and strobes each into instruction memory one cycle after its 4th byte.
// No backpressure: a byte landing on the write cycle starts the next word. LOADER_TIMEOUT_EN adds a RECV idle timeout.
module instruction_loader
  import mips_pkg::*;
#(
  parameter int SIZE_ADDR_PC   = 32,
  parameter int TOTAL_SIZE     = 256,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start_load,
  input  logic [BYTE_W-1:0]       i_rx_data,
  input  logic                    i_rx_done,
  output logic [SIZE_ADDR_PC-1:0] o_instruction_address,
  output logic [SIZE_ADDR_PC-1:0] o_instruction,
  output logic                    o_flag_write_intruc,
  output logic                    o_busy,
  output logic                    o_load_done,
  output logic                    o_error
);

  localparam int BYTES_PER_WORD = SIZE_ADDR_PC / BYTE_W;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD);

  localparam logic [CNT_W-1:0]        LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);
  localparam logic [SIZE_ADDR_PC-1:0] ADDR_STEP = SIZE_ADDR_PC'(BYTES_PER_WORD);
  localparam logic [SIZE_ADDR_PC-1:0] LAST_ADDR = SIZE_ADDR_PC'(TOTAL_SIZE - BYTES_PER_WORD);
  localparam logic [SIZE_ADDR_PC-1:0] HALT_WORD = SIZE_ADDR_PC'(HALT_INSTR);

  loader_state_t           state_q, state_d;
  logic [SIZE_ADDR_PC-1:0] addr_q, addr_d;
  logic [SIZE_ADDR_PC-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SIZE_ADDR_PC-1:0] instr_shift;
  logic                    timeout;

  assign instr_shift = {instr_q[SIZE_ADDR_PC-BYTE_W-1:0], i_rx_data};

`ifdef LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] idle_q;

  // Counts consecutive silent RECV cycles; any other state or an accepted byte restarts it.
  always_ff @(posedge i_clk) begin
    if (i_reset || (state_q != ST_RECV) || i_rx_done) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + TMO_W'(1);
    end
  end

  assign timeout = (state_q == ST_RECV) && !i_rx_done &&
                   (idle_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_start_load) begin
          state_d = ST_RECV;
          addr_d  = '0;
          instr_d = '0;
          cnt_d   = '0;
        end
      end
      ST_RECV: begin
        if (i_rx_done) begin
          instr_d = instr_shift;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BYTE) begin
            state_d = ST_WRITE;
          end
        end else if (timeout) begin
          state_d = ST_ERROR;
        end
      end
      ST_WRITE: begin
        // A byte arriving now is kept only if the load continues.
        if (instr_q == HALT_WORD) begin
          state_d = ST_DONE;
        end else if (addr_q == LAST_ADDR) begin
          state_d = ST_ERROR;
        end else begin
          state_d = ST_RECV;
          addr_d  = addr_q + ADDR_STEP;
          cnt_d   = '0;
          if (i_rx_done) begin
            instr_d = instr_shift;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_instruction_address = addr_q;
  assign o_instruction         = instr_q;
  assign o_flag_write_intruc   = (state_q == ST_WRITE);
  assign o_busy                = (state_q == ST_RECV) || (state_q == ST_WRITE);
  assign o_load_done           = (state_q == ST_DONE);
  assign o_error               = (state_q == ST_ERROR);

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: cycle vector table, directed loads, and random byte streams vs a word-level model.
module tb_instruction_loader;

  localparam logic [31:0] HALT      = 32'hFFFF_FFFF;
  localparam int          MEM_WORDS = 256 / 4;

  logic        clk = 1'b0;
  logic        rst, start, rxd;
  logic [7:0]  rxdat;
  logic [31:0] addr, ins;
  logic        strb, busy, done, err;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  bit prev_term = 1'b0;

  logic [31:0] mon_a[$];
  logic [31:0] mon_d[$];
  int          mon_c[$];

  typedef struct {
    logic        rst, start, rxd;
    logic [7:0]  dat;
    logic        strb, busy, done, err;
    logic [31:0] addr;
    logic        chk_ins;
    logic [31:0] ins;
  } vec_t;

  vec_t vt[$];

  instruction_loader dut (
    .i_clk                 (clk),
    .i_reset               (rst),
    .i_start_load          (start),
    .i_rx_data             (rxdat),
    .i_rx_done             (rxd),
    .o_instruction_address (addr),
    .o_instruction         (ins),
    .o_flag_write_intruc   (strb),
    .o_busy                (busy),
    .o_load_done           (done),
    .o_error               (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (strb === 1'b1) begin
      mon_a.push_back(addr);
      mon_d.push_back(ins);
      mon_c.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic vec_t mk(logic r, logic s, logic d, logic [7:0] b,
                              logic st, logic bu, logic dn, logic er,
                              logic [31:0] a, logic ck, logic [31:0] in);
    vec_t v;
    v.rst = r; v.start = s; v.rxd = d; v.dat = b;
    v.strb = st; v.busy = bu; v.done = dn; v.err = er;
    v.addr = a; v.chk_ins = ck; v.ins = in;
    return v;
  endfunction

  // Sends every byte of every word with random idle gaps, then compares the observed
  // writes against the words the loader should commit (up to HALT or a full memory).
  task automatic run_load(input string tag, input logic [31:0] words[$], input int max_gap);
    logic [31:0] exp_d[$];
    int          last_c[$];
    bit          halt;
    bit          term;
    int          n;
    halt = 1'b0;
    if (!prev_term) begin
      rst = 1'b1;
      step();
      rst = 1'b0;
      check({tag, ".rst_busy"}, busy, 0);
      check({tag, ".rst_done"}, done, 0);
      check({tag, ".rst_err"}, err, 0);
    end
    mon_a.delete();
    mon_d.delete();
    mon_c.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, ".start_busy"}, busy, 1);
    check({tag, ".start_done"}, done, 0);
    check({tag, ".start_err"}, err, 0);
    check({tag, ".start_addr"}, addr, 0);
    for (int i = 0; i < words.size(); i++) begin
      for (int b = 0; b < 4; b++) begin
        repeat ($urandom_range(0, max_gap)) step();
        rxd   = 1'b1;
        rxdat = words[i][31-8*b -: 8];
        if (b == 3) last_c.push_back(cyc);
        step();
        rxd = 1'b0;
      end
    end
    repeat (3) step();

    for (int i = 0; i < words.size() && !halt && exp_d.size() < MEM_WORDS; i++) begin
      exp_d.push_back(words[i]);
      halt = (words[i] == HALT);
    end
    term = halt || (exp_d.size() == MEM_WORDS);

    check({tag, ".write_count"}, mon_d.size(), exp_d.size());
    n = (mon_d.size() < exp_d.size()) ? mon_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s.w%0d_addr", tag, i), mon_a[i], 32'(4 * i));
      check($sformatf("%s.w%0d_data", tag, i), mon_d[i], exp_d[i]);
      check($sformatf("%s.w%0d_cycle", tag, i), mon_c[i], last_c[i] + 1);
    end
    check({tag, ".end_done"}, done, halt);
    check({tag, ".end_err"}, err, !halt && term);
    check({tag, ".end_busy"}, busy, !term);
    prev_term = term;
  endtask

  logic [31:0] w[$];
  int          len;

  initial begin
    rst = 1'b1; start = 1'b0; rxd = 1'b0; rxdat = 8'h00;
    step();
    step();

    // rst start rxd dat | strb busy done err addr chk ins
    vt.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0));
    vt.push_back(mk(0, 1, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 8'h00, 0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 8'h00, 0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 8'h00, 0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 8'h01, 1, 1, 0, 0, 0, 1, 32'h0000_0001));
    vt.push_back(mk(0, 0, 1, 8'hFF, 0, 1, 0, 0, 4, 0, 0));
    vt.push_back(mk(0, 0, 1, 8'hFF, 0, 1, 0, 0, 4, 0, 0));
    vt.push_back(mk(0, 0, 1, 8'hFF, 0, 1, 0, 0, 4, 0, 0));
    vt.push_back(mk(0, 0, 1, 8'hFF, 1, 1, 0, 0, 4, 1, HALT));
    vt.push_back(mk(0, 0, 1, 8'hAA, 0, 0, 1, 0, 4, 0, 0));
    vt.push_back(mk(0, 0, 1, 8'h55, 0, 0, 1, 0, 4, 0, 0));
    vt.push_back(mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 4, 0, 0));
    vt.push_back(mk(0, 1, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 8'h12, 0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 8'h34, 0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 8'h56, 0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 8'h78, 1, 1, 0, 0, 0, 1, 32'h1234_5678));
    vt.push_back(mk(0, 1, 0, 8'h00, 0, 1, 0, 0, 4, 0, 0));
    vt.push_back(mk(0, 0, 1, 8'hAB, 0, 1, 0, 0, 4, 0, 0));
    vt.push_back(mk(0, 0, 1, 8'hCD, 0, 1, 0, 0, 4, 0, 0));
    vt.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0));
    vt.push_back(mk(0, 1, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 8'h12, 0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 8'h34, 0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 8'h56, 0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 8'h78, 1, 1, 0, 0, 0, 1, 32'h1234_5678));
    vt.push_back(mk(0, 0, 0, 8'h00, 0, 1, 0, 0, 4, 0, 0));

    for (int i = 0; i < vt.size(); i++) begin
      rst   = vt[i].rst;
      start = vt[i].start;
      rxd   = vt[i].rxd;
      rxdat = vt[i].dat;
      step();
      rst = 1'b0; start = 1'b0; rxd = 1'b0;
      check($sformatf("vec%0d.strobe", i), strb, vt[i].strb);
      check($sformatf("vec%0d.busy", i), busy, vt[i].busy);
      check($sformatf("vec%0d.done", i), done, vt[i].done);
      check($sformatf("vec%0d.error", i), err, vt[i].err);
      check($sformatf("vec%0d.addr", i), addr, vt[i].addr);
      if (vt[i].chk_ins) check($sformatf("vec%0d.instr", i), ins, vt[i].ins);
    end
    prev_term = 1'b0;

    // Memory fill without HALT, bytes back to back, two extra words that must be dropped.
    w.delete();
    for (int k = 0; k < MEM_WORDS + 2; k++) w.push_back(32'h1000_0000 + 32'(k));
    run_load("fill", w, 0);

    w.delete();
    w.push_back(32'h0000_0001);
    w.push_back(HALT);
    w.push_back(32'hDEAD_BEEF);
    run_load("halt2", w, 1);

    for (int r = 0; r < 25; r++) begin
      w.delete();
      len = $urandom_range(1, 70);
      for (int k = 0; k < len; k++) w.push_back($urandom);
      if ($urandom_range(0, 2) != 0) w[$urandom_range(0, len - 1)] = HALT;
      run_load($sformatf("rnd%0d", r), w, 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
